// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: FSM states, WB/M control bit positions, bubble code.
package pipeline_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;

  localparam logic [1:0] BUBBLE_WB = 2'b00;
endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory valid/ready bus; the pipeline stage is master, the memory is slave.
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata,
                  input  dmem_ready, dmem_rdata);
  modport slave  (input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
                  output dmem_ready, dmem_rdata);
endinterface

// File: rtl/mem_access_stage_memwb.sv
// MEM/WB pipeline register. Bubble clears only the WB control; data fields hold.
module memwb_reg
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_bubble,
  input  logic        i_rd_load,
  input  logic [1:0]  i_wb,
  input  logic [31:0] i_alu,
  input  logic [4:0]  i_regd,
  input  logic [31:0] i_rdata,
  output logic [1:0]  o_wb,
  output logic [31:0] o_alu,
  output logic [4:0]  o_regd,
  output logic [31:0] o_rdata
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_wb    <= BUBBLE_WB;
      o_alu   <= '0;
      o_regd  <= '0;
      o_rdata <= '0;
    end else begin
      if (i_bubble) begin
        o_wb <= BUBBLE_WB;
      end else if (i_load) begin
        o_wb   <= i_wb;
        o_alu  <= i_alu;
        o_regd <= i_regd;
      end
      if (i_rd_load) o_rdata <= i_rdata;
    end
  end
endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: issues one registered dmem request per load/store,
// stalls upstream while it is outstanding, and fills MEM/WB toward write-back.
module mem_access_stage
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic                clk,
  input  logic                reset_in,
  input  logic [1:0]          WB_in,
  input  logic [1:0]          M_in,
  input  logic [31:0]         ALUData_in,
  input  logic [31:0]         WriteData_in,
  input  logic [4:0]          Regd_in,
  mem_access_stage_if.master  dmem,
  output logic                stall_out,
  output logic [1:0]          WB_out,
  output logic [31:0]         ReadData_out,
  output logic [31:0]         ALUData_out,
  output logic [4:0]          Regd_out,
  output logic                align_err_out,
  output logic                bus_err_out
);
  state_t                 r_state, w_next_state;
  logic [TIMEOUT_W-1:0]   r_cnt;
  logic [1:0]             r_wb;
  logic [4:0]             r_regd;
  logic                   r_req, r_we;
  logic [31:0]            r_addr, r_wdata;
  logic                   r_align_err, r_bus_err;

  logic        w_memop, w_illegal, w_issue, w_timeout, w_stall;
  logic        w_load, w_bubble, w_rd_load;
  logic [1:0]  w_wb_d;
  logic [31:0] w_alu_d;
  logic [4:0]  w_regd_d;

  assign w_memop   = M_in[M_MEMREAD] | M_in[M_MEMWRITE];
  assign w_illegal = (M_in == 2'b11) | (w_memop & (ALUData_in[1:0] != 2'b00));
  assign w_issue   = (r_state == IDLE) & w_memop & ~w_illegal;
  assign w_timeout = (r_state == BUSY) & ~dmem.dmem_ready &
                     (r_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    w_load       = 1'b0;
    w_bubble     = 1'b0;
    w_rd_load    = 1'b0;
    w_wb_d       = WB_in;
    w_alu_d      = ALUData_in;
    w_regd_d     = Regd_in;
    case (r_state)
      IDLE: begin
        if (w_illegal) begin
          w_bubble = 1'b1;
        end else if (w_memop) begin
          w_stall      = 1'b1;
          w_bubble     = 1'b1;
          w_next_state = BUSY;
        end else begin
          w_load = 1'b1;
        end
      end
      BUSY: begin
        // Ready on the final timeout cycle still counts as a normal completion.
        if (dmem.dmem_ready) begin
          w_load       = 1'b1;
          w_rd_load    = ~r_we;
          w_wb_d       = r_wb;
          w_alu_d      = r_addr;
          w_regd_d     = r_regd;
          w_next_state = IDLE;
        end else if (w_timeout) begin
          w_bubble     = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Stall is combinational from state; force it low while reset is held.
  assign stall_out = w_stall & reset_in;

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) r_state <= IDLE;
    else           r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      r_cnt       <= '0;
      r_wb        <= BUBBLE_WB;
      r_regd      <= '0;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_align_err <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_align_err <= (r_state == IDLE) & w_illegal;
      r_bus_err   <= w_timeout;
      if (w_issue) begin
        r_cnt   <= '0;
        r_wb    <= WB_in;
        r_regd  <= Regd_in;
        r_req   <= 1'b1;
        r_we    <= M_in[M_MEMWRITE];
        r_addr  <= ALUData_in;
        r_wdata <= WriteData_in;
      end else if (r_state == BUSY) begin
        if (dmem.dmem_ready || w_timeout) r_req <= 1'b0;
        else                              r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_wdata = r_wdata;
  assign align_err_out   = r_align_err;
  assign bus_err_out     = r_bus_err;

  memwb_reg u_memwb (
    .clk       (clk),
    .rst_n     (reset_in),
    .i_load    (w_load),
    .i_bubble  (w_bubble),
    .i_rd_load (w_rd_load),
    .i_wb      (w_wb_d),
    .i_alu     (w_alu_d),
    .i_regd    (w_regd_d),
    .i_rdata   (dmem.dmem_rdata),
    .o_wb      (WB_out),
    .o_alu     (ALUData_out),
    .o_regd    (Regd_out),
    .o_rdata   (ReadData_out)
  );
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a short timeout (4 BUSY cycles).
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        reset_in;
  logic [1:0]  WB_in, M_in;
  logic [31:0] ALUData_in, WriteData_in;
  logic [4:0]  Regd_in;
  logic        stall_out, align_err_out, bus_err_out;
  logic [1:0]  WB_out;
  logic [31:0] ReadData_out, ALUData_out;
  logic [4:0]  Regd_out;
  int n_chk = 0;
  int n_fail = 0;

  mem_access_stage_if dmem ();

  mem_access_stage #(.TIMEOUT_CYCLES(4), .TIMEOUT_W(8)) dut (
    .clk(clk), .reset_in(reset_in), .WB_in(WB_in), .M_in(M_in),
    .ALUData_in(ALUData_in), .WriteData_in(WriteData_in), .Regd_in(Regd_in),
    .dmem(dmem.master), .stall_out(stall_out), .WB_out(WB_out),
    .ReadData_out(ReadData_out), .ALUData_out(ALUData_out), .Regd_out(Regd_out),
    .align_err_out(align_err_out), .bus_err_out(bus_err_out));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input logic [1:0] wb, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] rd);
    M_in = m; WB_in = wb; ALUData_in = alu; WriteData_in = wd; Regd_in = rd;
    #1;
  endtask

  task automatic test_reset();
    reset_in = 1'b0;
    dmem.dmem_ready = 1'b0; dmem.dmem_rdata = '0;
    drive(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    repeat (2) tick();
    n_chk++; if ({dmem.dmem_req, dmem.dmem_we} !== 2'b00) begin n_fail++; $display("FAIL reset_req_we got %b exp 00", {dmem.dmem_req, dmem.dmem_we}); end
    n_chk++; if ({dmem.dmem_addr, dmem.dmem_wdata} !== 64'h0) begin n_fail++; $display("FAIL reset_addr_wdata got %h exp 0", {dmem.dmem_addr, dmem.dmem_wdata}); end
    n_chk++; if ({WB_out, Regd_out, ALUData_out, ReadData_out} !== 71'h0) begin n_fail++; $display("FAIL reset_memwb got %h exp 0", {WB_out, Regd_out, ALUData_out, ReadData_out}); end
    n_chk++; if ({stall_out, align_err_out, bus_err_out} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {stall_out, align_err_out, bus_err_out}); end
    @(negedge clk); reset_in = 1'b1;
  endtask

  task automatic test_passthrough();
    drive(2'b00, 2'b10, 32'h0000_1234, 32'h0, 5'd5);
    n_chk++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL pass_stall got %b exp 0", stall_out); end
    tick();
    n_chk++; if ({WB_out, ALUData_out, Regd_out} !== {2'b10, 32'h0000_1234, 5'd5}) begin n_fail++; $display("FAIL pass1 got %b %h %0d exp 10 1234 5", WB_out, ALUData_out, Regd_out); end
    drive(2'b00, 2'b01, 32'hABCD_0000, 32'h0, 5'd31);
    n_chk++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL pass2_stall got %b exp 0", stall_out); end
    tick();
    n_chk++; if ({WB_out, ALUData_out, Regd_out, ReadData_out, dmem.dmem_req} !== {2'b01, 32'hABCD_0000, 5'd31, 32'h0, 1'b0}) begin n_fail++; $display("FAIL pass2 got %b %h %0d rd=%h req=%b", WB_out, ALUData_out, Regd_out, ReadData_out, dmem.dmem_req); end
  endtask

  task automatic test_load_wait();
    int stalls = 0;
    drive(2'b10, 2'b11, 32'h0000_0100, 32'h0, 5'd7);
    if (stall_out) stalls++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (stall_out) stalls++;
      n_chk++; if ({dmem.dmem_req, dmem.dmem_we, dmem.dmem_addr, WB_out} !== {1'b1, 1'b0, 32'h100, 2'b00}) begin n_fail++; $display("FAIL load_busy%0d got req=%b we=%b addr=%h wb=%b", i, dmem.dmem_req, dmem.dmem_we, dmem.dmem_addr, WB_out); end
    end
    tick();
    dmem.dmem_ready = 1'b1; dmem.dmem_rdata = 32'hDEAD_BEEF;
    #1;
    n_chk++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL load_ready_stall got %b exp 0", stall_out); end
    n_chk++; if (stalls !== 4) begin n_fail++; $display("FAIL load_stall_cycles got %0d exp 4", stalls); end
    tick();
    dmem.dmem_ready = 1'b0;
    n_chk++; if ({WB_out, ReadData_out, ALUData_out, Regd_out, dmem.dmem_req} !== {2'b11, 32'hDEAD_BEEF, 32'h100, 5'd7, 1'b0}) begin n_fail++; $display("FAIL load_done got wb=%b rd=%h alu=%h regd=%0d req=%b", WB_out, ReadData_out, ALUData_out, Regd_out, dmem.dmem_req); end
  endtask

  task automatic test_back_to_back();
    drive(2'b01, 2'b00, 32'h0000_0204, 32'hCAFE_0001, 5'd3);
    n_chk++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL store_stall got %b exp 1", stall_out); end
    tick();
    n_chk++; if ({dmem.dmem_req, dmem.dmem_we, dmem.dmem_addr, dmem.dmem_wdata} !== {2'b11, 32'h204, 32'hCAFE_0001}) begin n_fail++; $display("FAIL store_bus got req=%b we=%b addr=%h wd=%h", dmem.dmem_req, dmem.dmem_we, dmem.dmem_addr, dmem.dmem_wdata); end
    dmem.dmem_ready = 1'b1; #1;
    n_chk++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL store_ready_stall got %b exp 0", stall_out); end
    tick();
    dmem.dmem_ready = 1'b0;
    n_chk++; if ({WB_out, ALUData_out, Regd_out, ReadData_out} !== {2'b00, 32'h204, 5'd3, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL store_done got wb=%b alu=%h regd=%0d rd=%h", WB_out, ALUData_out, Regd_out, ReadData_out); end
    drive(2'b10, 2'b11, 32'h0000_0300, 32'h0, 5'd9);
    n_chk++; if ({dmem.dmem_req, stall_out} !== 2'b01) begin n_fail++; $display("FAIL b2b_gap got req=%b stall=%b exp 0 1", dmem.dmem_req, stall_out); end
    tick();
    n_chk++; if ({dmem.dmem_req, dmem.dmem_we, dmem.dmem_addr} !== {2'b10, 32'h300}) begin n_fail++; $display("FAIL b2b_req got req=%b we=%b addr=%h", dmem.dmem_req, dmem.dmem_we, dmem.dmem_addr); end
    dmem.dmem_ready = 1'b1; dmem.dmem_rdata = 32'h1234_5678;
    tick();
    dmem.dmem_ready = 1'b0;
    n_chk++; if ({WB_out, ReadData_out, Regd_out} !== {2'b11, 32'h1234_5678, 5'd9}) begin n_fail++; $display("FAIL b2b_done got wb=%b rd=%h regd=%0d", WB_out, ReadData_out, Regd_out); end
  endtask

  task automatic test_illegal();
    drive(2'b00, 2'b10, 32'h0000_0010, 32'h0, 5'd2);
    tick();
    drive(2'b10, 2'b11, 32'h0000_0102, 32'h0, 5'd4);
    n_chk++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL misalign_stall got %b exp 0", stall_out); end
    tick();
    n_chk++; if ({align_err_out, WB_out, dmem.dmem_req} !== {1'b1, 2'b00, 1'b0}) begin n_fail++; $display("FAIL misalign got err=%b wb=%b req=%b", align_err_out, WB_out, dmem.dmem_req); end
    drive(2'b11, 2'b10, 32'h0000_0200, 32'h0, 5'd4);
    n_chk++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL illegal_stall got %b exp 0", stall_out); end
    tick();
    n_chk++; if ({align_err_out, WB_out, dmem.dmem_req} !== {1'b1, 2'b00, 1'b0}) begin n_fail++; $display("FAIL illegal got err=%b wb=%b req=%b", align_err_out, WB_out, dmem.dmem_req); end
    drive(2'b00, 2'b10, 32'h0000_0020, 32'h0, 5'd2);
    tick();
    n_chk++; if ({align_err_out, WB_out} !== {1'b0, 2'b10}) begin n_fail++; $display("FAIL illegal_clear got err=%b wb=%b", align_err_out, WB_out); end
  endtask

  task automatic test_timeout();
    drive(2'b10, 2'b11, 32'h0000_0400, 32'h0, 5'd8);
    tick();
    for (int i = 0; i < 3; i++) begin
      n_chk++; if ({stall_out, dmem.dmem_req} !== 2'b11) begin n_fail++; $display("FAIL to_wait%0d got stall=%b req=%b", i, stall_out, dmem.dmem_req); end
      tick();
    end
    n_chk++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL to_last_stall got %b exp 0", stall_out); end
    tick();
    n_chk++; if ({bus_err_out, dmem.dmem_req, WB_out} !== {1'b1, 1'b0, 2'b00}) begin n_fail++; $display("FAIL to_abort got err=%b req=%b wb=%b", bus_err_out, dmem.dmem_req, WB_out); end
    drive(2'b00, 2'b01, 32'h0000_0055, 32'h0, 5'd1);
    tick();
    n_chk++; if ({bus_err_out, WB_out, ALUData_out} !== {1'b0, 2'b01, 32'h55}) begin n_fail++; $display("FAIL to_after got err=%b wb=%b alu=%h", bus_err_out, WB_out, ALUData_out); end
    drive(2'b10, 2'b11, 32'h0000_0500, 32'h0, 5'd6);
    repeat (4) tick();
    dmem.dmem_ready = 1'b1; dmem.dmem_rdata = 32'h0BAD_F00D; #1;
    tick();
    dmem.dmem_ready = 1'b0;
    n_chk++; if ({bus_err_out, WB_out, ReadData_out, Regd_out} !== {1'b0, 2'b11, 32'h0BAD_F00D, 5'd6}) begin n_fail++; $display("FAIL to_late_ready got err=%b wb=%b rd=%h regd=%0d", bus_err_out, WB_out, ReadData_out, Regd_out); end
  endtask

  task automatic test_reset_busy();
    drive(2'b10, 2'b11, 32'h0000_0600, 32'h0, 5'd10);
    tick();
    n_chk++; if (dmem.dmem_req !== 1'b1) begin n_fail++; $display("FAIL rb_req got %b exp 1", dmem.dmem_req); end
    #2 reset_in = 1'b0; #1;
    n_chk++; if ({dmem.dmem_req, WB_out, stall_out} !== 4'b0000) begin n_fail++; $display("FAIL rb_async got req=%b wb=%b stall=%b", dmem.dmem_req, WB_out, stall_out); end
    drive(2'b00, 2'b10, 32'h0000_0077, 32'h0, 5'd12);
    @(negedge clk); reset_in = 1'b1;
    tick();
    n_chk++; if ({dmem.dmem_req, stall_out, WB_out, ALUData_out, Regd_out} !== {2'b00, 2'b10, 32'h77, 5'd12}) begin n_fail++; $display("FAIL rb_release got req=%b stall=%b wb=%b alu=%h regd=%0d", dmem.dmem_req, stall_out, WB_out, ALUData_out, Regd_out); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load_wait();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access pipeline stage. It consumes the EX/MEM register outputs (WB, M, ALU result, store data, destination register) and runs a valid/ready handshake to the data memory.
- It stalls the upstream pipeline while an access is outstanding.
- It drives the MEM/WB pipeline register contents (WB, read data, ALU result, destination register) toward write-back.
- Non-memory instructions pass through with one cycle of latency.

Parameters:
- TIMEOUT_CYCLES, 255: maximum BUSY cycles waiting for dmem_ready before the access is aborted.
- TIMEOUT_W, 8: width of the timeout counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset_in  in  1  asynchronous, active-low reset.
- WB_in  in  2  {RegWrite, MemtoReg} from EX/MEM.
- M_in  in  2  {MemRead, MemWrite} from EX/MEM.
- ALUData_in  in  32  ALU result; byte address for loads and stores.
- WriteData_in  in  32  store data.
- Regd_in  in  5  destination register.
- dmem_ready  in  1  memory accepts or completes the current request.
- dmem_rdata  in  32  load data; valid when dmem_ready=1 and dmem_we=0.
- dmem_req  out  1  request valid.
- dmem_we  out  1  1=write, 0=read.
- dmem_addr  out  32  word-aligned address.
- dmem_wdata  out  32  store data.
- stall_out  out  1  freezes the PC, IF/ID, ID/EX and EX/MEM registers.
- WB_out  out  2  MEM/WB control; 2'b00 means bubble.
- ReadData_out  out  32  registered load data.
- ALUData_out  out  32  registered ALU result.
- Regd_out  out  5  registered destination register.
- align_err_out  out  1  one-cycle pulse: misaligned or illegal memory op.
- bus_err_out  out  1  one-cycle pulse: access timed out.

Behaviour:
- Reset (reset_in=0, asynchronous):
  - State IDLE, timeout counter 0.
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.
  - WB_out=0, ReadData_out=0, ALUData_out=0, Regd_out=0, both error flags 0.
  - stall_out=0.
  - A reset during BUSY drops dmem_req immediately; the access is abandoned.
- FSM states: IDLE, BUSY.
- Signal definitions:
  - memop = M_in[1] | M_in[0].
  - illegal = (M_in == 2'b11) | (memop & (ALUData_in[1:0] != 0)).
- IDLE, memop=0:
  - Next edge: MEM/WB <= {WB_in, ALUData_in, Regd_in}; ReadData_out holds its previous value.
  - stall_out=0. Latency is 1 cycle.
- IDLE, illegal=1:
  - No request issued, stall_out=0.
  - Next edge: WB_out<=0 (bubble), align_err_out<=1 for one cycle, state stays IDLE.
- IDLE, memop=1 and illegal=0:
  - stall_out=1 (combinational, same cycle).
  - Next edge: latch dmem_addr=ALUData_in, dmem_wdata=WriteData_in, dmem_we=M_in[0], dmem_req<=1.
  - Also latch WB_in and Regd_in internally, clear the timeout counter, WB_out<=0 (bubble), state->BUSY.
- BUSY, dmem_ready=0:
  - stall_out=1. dmem_req, dmem_we, dmem_addr and dmem_wdata held stable. Counter increments.
- BUSY, dmem_ready=1:
  - stall_out=0 (combinational).
  - Next edge: WB_out<=latched WB and Regd_out<=latched Regd.
  - ALUData_out<=dmem_addr; ReadData_out<=dmem_rdata for a read, held for a write.
  - dmem_req<=0, state->IDLE. EX/MEM advances on the same edge.
- BUSY, counter==TIMEOUT_CYCLES-1 and dmem_ready=0:
  - stall_out=0.
  - Next edge: dmem_req<=0, WB_out<=0, bus_err_out<=1 for one cycle, state->IDLE.
  - dmem_ready arriving on that same cycle wins (normal completion, no error).
- Minimum memory-op latency: 2 cycles (IDLE and BUSY) when dmem_ready is high on the first BUSY cycle.
- Back-to-back memory ops: the second op is presented in IDLE on the cycle after completion, so there is exactly one dmem_req=0 gap between requests.
- Stores keep their WB control (normally RegWrite=0); this stage never forces RegWrite. The MemtoReg mux lives in write-back.
- dmem_req is never asserted combinationally from M_in; all memory-bus outputs are registered.

Decomposition:
- Shared package pipeline_pkg:
  - State enum {IDLE, BUSY}.
  - Bit indices WB_REGWRITE=1, WB_MEMTOREG=0, M_MEMREAD=1, M_MEMWRITE=0.
  - Constant BUBBLE_WB=2'b00.
- Natural sub-module: memwb_reg.
  - Holds the MEM/WB output register with async active-low reset.
  - Load-enable and bubble-insert inputs.
  - Instanced once here.

Test Plan:
- Reset: assert reset_in=0 mid-BUSY with dmem_req=1 → dmem_req, WB_out and stall_out are 0 immediately; state IDLE after release.
- ALU passthrough: M_in=00, WB_in=10, ALUData_in=0x0000_1234, Regd_in=5 → next cycle WB_out=10, ALUData_out=0x1234, Regd_out=5; stall_out never asserted.
- Load with 3-cycle wait: M_in=10, addr 0x100, dmem_ready low for 3 BUSY cycles then high with rdata 0xDEAD_BEEF → stall_out high 4 cycles; dmem_addr steady at 0x100; then ReadData_out=0xDEADBEEF, WB_out=latched value.
- Store with immediate ready: M_in=01, addr 0x204, data 0xCAFE_0001 → dmem_we=1, dmem_wdata=0xCAFE0001, stall_out high 1 cycle, completion on the next edge.
- Misaligned or illegal: addr 0x102 with M_in=10, then M_in=11 → no dmem_req; align_err_out pulses once each; WB_out=00; no stall.
- Timeout: TIMEOUT_CYCLES=4, dmem_ready held 0 → bus_err_out pulses after 4 BUSY cycles, dmem_req drops, WB_out=00. Repeat with dmem_ready rising on the last cycle → normal completion, no error.
